// File: rtl/haraka_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | haraka_pkg : shared types and sizes for the Haraka-S sponge padder     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package haraka_pkg;

  localparam int RATE_BITS_DEFAULT = 256;
  localparam int BLOCK_COUNT_W     = 16;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    EMIT = 2'd1,
    PAD  = 2'd2,
    DONE = 2'd3
  } padder_state_e;

endpackage
`default_nettype wire

// File: rtl/haraka_s_padder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | haraka_s_padder : bit-serial pad10*1 padder producing rate blocks      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module haraka_s_padder
  import haraka_pkg::*;
#(
  parameter int RATE_BITS = RATE_BITS_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     bit_in,
  input  logic                     bit_valid,
  input  logic                     bit_last,
  output logic                     bit_ready,
  output logic [RATE_BITS-1:0]     block_out,
  output logic                     block_valid,
  input  logic                     block_ready,
  output logic                     block_last,
  output logic                     squeeze_start,
  output logic [BLOCK_COUNT_W-1:0] block_count
);

  localparam int                IDX_W   = $clog2(RATE_BITS);
  localparam logic [IDX_W-1:0]  IDX_MAX = IDX_W'(RATE_BITS - 1);
  localparam logic [IDX_W-1:0]  IDX_K2  = IDX_W'(RATE_BITS - 2);
  localparam logic [IDX_W-1:0]  IDX_K3  = IDX_W'(RATE_BITS - 3);

  padder_state_e              r_state;
  padder_state_e              w_next;
  logic [RATE_BITS-1:0]       r_block;
  logic [IDX_W-1:0]           r_idx;
  logic [IDX_W-1:0]           w_idx_inc;
  logic                       r_pad_pending;
  logic                       r_start_pad;
  logic                       r_last;
  logic [BLOCK_COUNT_W-1:0]   r_count;
  logic                       w_accept;

  assign bit_ready     = (r_state == FILL) & ~reset;
  assign block_valid   = (r_state == EMIT);
  assign block_out     = r_block;
  assign block_last    = r_last & (r_state == EMIT);
  assign squeeze_start = (r_state == DONE);
  assign block_count   = r_count;

  assign w_accept  = bit_valid & bit_ready;
  assign w_idx_inc = r_idx + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FILL;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      FILL: begin
        if (w_accept && (bit_last || (r_idx == IDX_MAX))) begin
          w_next = EMIT;
        end
      end
      EMIT: begin
        if (block_ready) begin
          if (r_last) begin
            w_next = DONE;
          end else if (r_pad_pending) begin
            w_next = PAD;
          end else begin
            w_next = FILL;
          end
        end
      end
      PAD:     w_next = EMIT;
      DONE:    w_next = FILL;
      default: w_next = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_block       <= '0;
      r_idx         <= '0;
      r_pad_pending <= 1'b0;
      r_start_pad   <= 1'b0;
      r_last        <= 1'b0;
      r_count       <= '0;
    end else begin
      case (r_state)
        FILL: begin
          if (w_accept) begin
            r_block[r_idx] <= bit_in;
            if (bit_last) begin
              // Where the closing pad bits land depends on how much room is left in this block.
              if (r_idx <= IDX_K3) begin
                r_block[w_idx_inc]     <= 1'b1;
                r_block[RATE_BITS-1]   <= 1'b1;
                r_last                 <= 1'b1;
              end else if (r_idx == IDX_K2) begin
                r_block[RATE_BITS-1]   <= 1'b1;
                r_pad_pending          <= 1'b1;
              end else begin
                r_pad_pending          <= 1'b1;
                r_start_pad            <= 1'b1;
              end
            end else if (r_idx != IDX_MAX) begin
              r_idx <= w_idx_inc;
            end
          end
        end
        EMIT: begin
          if (block_ready) begin
            if (r_count != '1) begin
              r_count <= r_count + BLOCK_COUNT_W'(1);
            end
            if (!r_last && !r_pad_pending) begin
              r_block <= '0;
              r_idx   <= '0;
            end
          end
        end
        PAD: begin
          r_block              <= '0;
          r_block[RATE_BITS-1] <= 1'b1;
          r_block[0]           <= r_start_pad;
          r_last               <= 1'b1;
          r_pad_pending        <= 1'b0;
          r_start_pad          <= 1'b0;
        end
        DONE: begin
          r_block <= '0;
          r_idx   <= '0;
          r_count <= '0;
          r_last  <= 1'b0;
        end
        default: begin
          r_block <= '0;
          r_idx   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_haraka_s_padder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_haraka_s_padder : directed vector bench for haraka_s_padder         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_haraka_s_padder;

  localparam int RATE = 256;

  typedef struct {
    int          len;
    logic [31:0] pat;
    int          stall;
    int          nb;
  } vec_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            bit_in;
  logic            bit_valid;
  logic            bit_last;
  logic            bit_ready;
  logic [RATE-1:0] block_out;
  logic            block_valid;
  logic            block_ready;
  logic            block_last;
  logic            squeeze_start;
  logic [15:0]     block_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  haraka_s_padder #(.RATE_BITS(RATE)) dut (
    .clk           (clk),
    .reset         (reset),
    .bit_in        (bit_in),
    .bit_valid     (bit_valid),
    .bit_last      (bit_last),
    .bit_ready     (bit_ready),
    .block_out     (block_out),
    .block_valid   (block_valid),
    .block_ready   (block_ready),
    .block_last    (block_last),
    .squeeze_start (squeeze_start),
    .block_count   (block_count)
  );

  task automatic check_v(input string name, input logic [RATE-1:0] act, input logic [RATE-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Padded stream: message, a 1 right after it, zeros, and a 1 closing the final block.
  function automatic logic exp_bit(input vec_t v, input int pos);
    if (pos < v.len) return v.pat[pos % 32];
    return (pos == v.len) || (pos == v.nb * RATE - 1);
  endfunction

  function automatic logic [RATE-1:0] build(input vec_t v, input int blk);
    logic [RATE-1:0] b;
    for (int i = 0; i < RATE; i++) b[i] = exp_bit(v, blk * RATE + i);
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_msg(input vec_t v);
    int idx, blk, stall_left, cyc;
    bit done, acc;
    idx = 0; blk = 0; stall_left = v.stall; cyc = 0; done = 0;
    while (!done && cyc < 4000) begin
      bit_valid   = (idx < v.len);
      bit_in      = (idx < v.len) ? v.pat[idx % 32] : 1'b0;
      bit_last    = (idx == v.len - 1);
      block_ready = 1'b0;
      acc = bit_valid && bit_ready;
      if (block_valid) begin
        check_v("block_out", block_out, build(v, blk));
        check_i("block_last", int'(block_last), int'(blk == v.nb - 1));
        check_i("count_before_take", int'(block_count), blk);
        check_i("bit_ready_in_emit", int'(bit_ready), 0);
        if (stall_left > 0) begin
          stall_left--;
        end else begin
          block_ready = 1'b1;
          blk++;
          stall_left = v.stall;
        end
      end
      if (squeeze_start) begin
        check_i("blocks_at_squeeze", blk, v.nb);
        check_i("count_at_squeeze", int'(block_count), v.nb);
        done = 1;
      end
      tick();
      cyc++;
      if (acc) idx++;
    end
    bit_valid   = 1'b0;
    bit_last    = 1'b0;
    block_ready = 1'b0;
    if (!done) check_i("squeeze_timeout", 0, 1);
    check_i("squeeze_one_cycle", int'(squeeze_start), 0);
    check_i("ready_after_done", int'(bit_ready), 1);
    check_i("count_cleared", int'(block_count), 0);
  endtask

  vec_t vecs[8];
  vec_t va5;

  initial begin
    vecs[0] = '{len: 1,   pat: 32'hFFFF_FFFF, stall: 0,  nb: 1};
    vecs[1] = '{len: 255, pat: 32'h0000_0000, stall: 0,  nb: 2};
    vecs[2] = '{len: 256, pat: 32'hFFFF_FFFF, stall: 0,  nb: 2};
    vecs[3] = '{len: 300, pat: 32'h5555_5555, stall: 10, nb: 2};
    vecs[4] = '{len: 254, pat: 32'hA5A5_0F0F, stall: 0,  nb: 1};
    vecs[5] = '{len: 512, pat: 32'hFFFF_FFFF, stall: 3,  nb: 3};
    vecs[6] = '{len: 511, pat: 32'h3C3C_3C3C, stall: 0,  nb: 3};
    vecs[7] = '{len: 257, pat: 32'h0000_0001, stall: 1,  nb: 2};
    va5     = '{len: 8,   pat: 32'h0000_00A5, stall: 0,  nb: 1};

    reset = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; bit_last = 1'b0; block_ready = 1'b0;
    repeat (3) tick();
    check_i("rst_bit_ready", int'(bit_ready), 0);
    check_i("rst_block_valid", int'(block_valid), 0);
    check_i("rst_block_last", int'(block_last), 0);
    check_i("rst_squeeze", int'(squeeze_start), 0);
    check_i("rst_count", int'(block_count), 0);
    check_v("rst_block_out", block_out, '0);
    reset = 1'b0;
    #1;
    check_i("ready_after_release", int'(bit_ready), 1);

    foreach (vecs[i]) run_msg(vecs[i]);

    // Partial message then reset: nothing of it may survive.
    bit_valid = 1'b1; bit_in = 1'b1; bit_last = 1'b0; block_ready = 1'b1;
    repeat (100) tick();
    bit_valid = 1'b0;
    reset = 1'b1;
    tick();
    check_i("midmsg_rst_ready", int'(bit_ready), 0);
    check_i("midmsg_rst_valid", int'(block_valid), 0);
    reset = 1'b0;
    #1;
    check_i("midmsg_ready_release", int'(bit_ready), 1);
    block_ready = 1'b0;
    run_msg(va5);

    // Full block held in EMIT, then reset.
    bit_valid = 1'b1; bit_in = 1'b1; bit_last = 1'b0; block_ready = 1'b0;
    repeat (256) tick();
    bit_valid = 1'b0;
    check_i("emit_valid", int'(block_valid), 1);
    repeat (3) tick();
    check_v("emit_held", block_out, '1);
    check_i("emit_held_valid", int'(block_valid), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check_i("post_rst_no_block", int'(block_valid), 0);
      check_i("post_rst_no_squeeze", int'(squeeze_start), 0);
      block_ready = 1'b1;
      tick();
    end
    block_ready = 1'b0;
    run_msg(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
